// File: rtl/regfile_wb_queue_pkg.sv
// regwb_pkg: shared widths, the zero-register constant and the writeback queue entry type.
package regwb_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: ALU and memory writeback result buses feeding the queue.
// master drives valid/waddr/data for both sources; slave returns the two ready signals.
interface regfile_wb_queue_if;
   import regwb_pkg::*;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_waddr;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_data;
   modport master (output alu_valid, alu_waddr, alu_data, mem_valid, mem_waddr, mem_data,
                   input alu_ready, mem_ready);
   modport slave (input alu_valid, alu_waddr, alu_data, mem_valid, mem_waddr, mem_data,
                  output alu_ready, mem_ready);
endinterface

// File: rtl/regfile_wb_queue_bypass.sv
// wb_bypass_match: youngest-match search over pending writebacks for one lookup port.
// raddr_i lookup address; ent_i/vld_i queue entries ordered oldest to youngest;
// out_vld_i/out_i output register (oldest candidate); hit_o/data_o lookup result.
module wb_bypass_match
   import regwb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [ADDR_W-1:0] raddr_i,
   input  wb_entry_t         ent_i [DEPTH],
   input  logic [DEPTH-1:0]  vld_i,
   input  logic              out_vld_i,
   input  wb_entry_t         out_i,
   output logic              hit_o,
   output logic [DATA_W-1:0] data_o
);
   // Later matches overwrite earlier ones, so the youngest candidate wins.
   always_comb begin
      hit_o = 1'b0;
      data_o = '0;
      if (raddr_i != REG_ZERO) begin
         if (out_vld_i && out_i.waddr == raddr_i) begin
            hit_o = 1'b1;
            data_o = out_i.data;
         end
         for (int i = 0; i < DEPTH; i++)
            if (vld_i[i] && ent_i[i].waddr == raddr_i) begin
               hit_o = 1'b1;
               data_o = ent_i[i].data;
            end
      end
   end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue draining into the register-file write port.
// clk/nrst clock and async active-low reset; bus ALU/memory result handshakes (memory first);
// port_busy stalls the drain; wr/waddr/din registered write port; raddr1/2 -> hit1/2, bdata1/2
// combinational bypass; count occupancy; empty when nothing is queued or being written.
module regfile_wb_queue
   import regwb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nrst,
   regfile_wb_queue_if.slave        bus,
   input  logic                     port_busy,
   output logic                     wr,
   output logic [ADDR_W-1:0]        waddr,
   output logic [DATA_W-1:0]        din,
   input  logic [ADDR_W-1:0]        raddr1,
   input  logic [ADDR_W-1:0]        raddr2,
   output logic                     hit1,
   output logic                     hit2,
   output logic [DATA_W-1:0]        bdata1,
   output logic [DATA_W-1:0]        bdata2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   wb_entry_t         q_q [DEPTH];
   wb_entry_t         ord [DEPTH];
   logic [DEPTH-1:0]  ord_vld;
   logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   wb_entry_t         out_q, out_d, in_e;
   logic              wr_q, full, acc_mem, acc_alu, push, pop;
   // Full looks only at the registered count: a same-cycle pop never frees a slot for a push.
   always_comb begin
      full = cnt_q == CW'(DEPTH);
      acc_mem = bus.mem_valid && !full;
      acc_alu = bus.alu_valid && !full && !bus.mem_valid;
      in_e = acc_mem ? {bus.mem_waddr, bus.mem_data} : {bus.alu_waddr, bus.alu_data};
      push = (acc_mem || acc_alu) && in_e.waddr != REG_ZERO;
      pop = cnt_q != '0 && !port_busy;
      wp_d = wp_q + PW'(push);
      rp_d = rp_q + PW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      out_d = pop ? q_q[rp_q] : out_q;
   end
   assign bus.mem_ready = !full;
   assign bus.alu_ready = !full && !bus.mem_valid;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
         wr_q <= 1'b0;
         out_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
         wr_q <= pop;
         out_q <= out_d;
      end
   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk)
      if (push) q_q[wp_q] <= in_e;
   // Present the live entries oldest-first so the matcher can rank by position.
   always_comb
      for (int i = 0; i < DEPTH; i++) begin
         ord[i] = q_q[rp_q + PW'(i)];
         ord_vld[i] = CW'(i) < cnt_q;
      end
   wb_bypass_match #(.DEPTH(DEPTH)) u_bp1 (
      .raddr_i(raddr1), .ent_i(ord), .vld_i(ord_vld), .out_vld_i(wr_q), .out_i(out_q),
      .hit_o(hit1), .data_o(bdata1)
   );
   wb_bypass_match #(.DEPTH(DEPTH)) u_bp2 (
      .raddr_i(raddr2), .ent_i(ord), .vld_i(ord_vld), .out_vld_i(wr_q), .out_i(out_q),
      .hit_o(hit2), .data_o(bdata2)
   );
   assign wr = wr_q;
   assign waddr = out_q.waddr;
   assign din = out_q.data;
   assign count = cnt_q;
   assign empty = cnt_q == '0 && !wr_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed and random stimulus checked against a queue-based reference model.
module tb_regfile_wb_queue;
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        port_busy = 1'b0;
   logic [4:0]  raddr1 = '0, raddr2 = '0;
   logic        wr, hit1, hit2, empty;
   logic [4:0]  waddr;
   logic [31:0] din, bdata1, bdata2;
   logic [2:0]  count;
   int          checks = 0, failures = 0;
   ent_t        mq[$];
   logic        m_wr = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_din = '0;
   regfile_wb_queue_if bus();
   regfile_wb_queue #(.DEPTH(4)) dut (
      .clk(clk), .nrst(nrst), .bus(bus), .port_busy(port_busy),
      .wr(wr), .waddr(waddr), .din(din), .raddr1(raddr1), .raddr2(raddr2),
      .hit1(hit1), .hit2(hit2), .bdata1(bdata1), .bdata2(bdata2),
      .count(count), .empty(empty)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Pending results: the write-port register first (oldest), then the queue in arrival order.
   function automatic void bypass(input logic [4:0] r, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (r != 5'd0) begin
         if (m_wr && m_waddr == r) begin
            h = 1'b1;
            d = m_din;
         end
         foreach (mq[i])
            if (mq[i].a == r) begin
               h = 1'b1;
               d = mq[i].d;
            end
      end
   endfunction
   task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic busy, input logic [4:0] r1, input logic [4:0] r2);
      logic        full, h;
      logic [31:0] d;
      ent_t        e;
      bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_data = ad;
      bus.mem_valid = mv; bus.mem_waddr = ma; bus.mem_data = md;
      port_busy = busy; raddr1 = r1; raddr2 = r2;
      #1;
      full = mq.size() == 4;
      chk("mem_ready", 32'(bus.mem_ready), 32'(!full));
      chk("alu_ready", 32'(bus.alu_ready), 32'(!full && !mv));
      chk("count", 32'(count), mq.size());
      chk("wr", 32'(wr), 32'(m_wr));
      chk("waddr", 32'(waddr), 32'(m_waddr));
      chk("din", din, m_din);
      chk("empty", 32'(empty), 32'(mq.size() == 0 && !m_wr));
      bypass(r1, h, d);
      chk("hit1", 32'(hit1), 32'(h));
      chk("bdata1", bdata1, d);
      bypass(r2, h, d);
      chk("hit2", 32'(hit2), 32'(h));
      chk("bdata2", bdata2, d);
      if (mq.size() > 0 && !busy) begin
         e = mq.pop_front();
         m_wr = 1'b1; m_waddr = e.a; m_din = e.d;
      end else m_wr = 1'b0;
      if (!full && (mv || av)) begin
         e.a = mv ? ma : aa;
         e.d = mv ? md : ad;
         if (e.a != 5'd0) mq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n, input logic busy, input logic [4:0] r1);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, busy, r1, 5'd7);
   endtask
   task automatic alu(input logic [4:0] a, input logic [31:0] d, input logic busy, input logic [4:0] r1);
      step(1, a, d, 0, 0, 0, busy, r1, a);
   endtask
   initial begin
      bus.alu_valid = 0; bus.alu_waddr = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_waddr = 0; bus.mem_data = 0;
      #3;
      chk("rst_wr", 32'(wr), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_din", din, 0);
      #4 nrst = 1'b1;
      @(posedge clk);
      #1;
      // Single ALU result r3
      alu(5'd3, 32'hAA, 0, 5'd3);
      idle(1, 0, 5'd3);
      chk("t1_wr", 32'(wr), 1);
      chk("t1_waddr", 32'(waddr), 3);
      chk("t1_din", din, 32'hAA);
      chk("t1_hit", 32'(hit1), 1);
      idle(2, 0, 5'd3);
      // Simultaneous ALU and memory results
      step(1, 5'd4, 32'h11, 1, 5'd5, 32'h22, 0, 5'd4, 5'd5);
      alu(5'd4, 32'h11, 0, 5'd5);
      chk("arb_wr_r5", 32'(waddr), 5);
      idle(1, 0, 5'd4);
      chk("arb_wr_r4", 32'(waddr), 4);
      idle(2, 0, 5'd0);
      // Fill while the write port is busy
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 5'(8 + i), 32'(100 + i), 1, 5'(8 + i), 5'd9);
      chk("fill_count", 32'(count), 4);
      chk("fill_mready", 32'(bus.mem_ready), 0);
      chk("fill_aready", 32'(bus.alu_ready), 0);
      step(1, 5'd12, 32'h55, 1, 5'd12, 32'h66, 1, 5'd12, 5'd8);
      idle(5, 0, 5'd10);
      for (int i = 0; i < 5; i++) alu(5'(16 + i), 32'(200 + i), 0, 5'(16 + i));
      idle(3, 0, 5'd18);
      // Youngest of several pending r7 writes wins
      alu(5'd7, 32'h9, 1, 5'd7);
      alu(5'd7, 32'h1, 1, 5'd7);
      alu(5'd7, 32'h2, 0, 5'd7);
      chk("yw_wr", 32'(wr), 1);
      chk("yw_hit", 32'(hit1), 1);
      chk("yw_data", bdata1, 32'h2);
      idle(4, 0, 5'd7);
      // r0 writes are accepted and dropped
      alu(5'd0, 32'hFFFF, 0, 5'd0);
      chk("r0_count", 32'(count), 0);
      idle(2, 0, 5'd0);
      // Reset mid-drain
      for (int i = 0; i < 4; i++) alu(5'(10 + i), 32'(300 + i), 1, 5'd11);
      idle(1, 0, 5'd11);
      chk("mr_count", 32'(count), 3);
      chk("mr_wr", 32'(wr), 1);
      #2 nrst = 1'b0;
      #1;
      chk("mr_wr0", 32'(wr), 0);
      chk("mr_waddr0", 32'(waddr), 0);
      chk("mr_din0", din, 0);
      chk("mr_count0", 32'(count), 0);
      chk("mr_empty", 32'(empty), 1);
      chk("mr_hit", 32'(hit1), 0);
      mq.delete();
      m_wr = 1'b0; m_waddr = '0; m_din = '0;
      #1 nrst = 1'b1;
      @(posedge clk);
      #1;
      alu(5'd2, 32'h5, 0, 5'd2);
      idle(3, 0, 5'd2);
      // Random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      idle(6, 0, 5'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
